// File: rtl/ssp_mstr_if.sv
// ssp_mstr_if: host command bus and SSP pins of the ssp_mstr SPI mode 0 initiator.
// The master modport is the initiator's view; the slave modport is the view of
// whatever drives commands and models the SSP slave (host controller or bench).
interface ssp_mstr_if;
  logic        Req;
  logic [2:0]  RA;
  logic        WnR;
  logic [11:0] DI;
  logic        Ack;
  logic        Busy;
  logic        Done;
  logic        RdVld;
  logic [11:0] RdData;
  logic        SSP_SSEL;
  logic        SSP_SCK;
  logic        SSP_MOSI;
  logic        SSP_MISO;

  modport master (
    input  Req, RA, WnR, DI, SSP_MISO,
    output Ack, Busy, Done, RdVld, RdData, SSP_SSEL, SSP_SCK, SSP_MOSI
  );

  modport slave (
    output Req, RA, WnR, DI, SSP_MISO,
    input  Ack, Busy, Done, RdVld, RdData, SSP_SSEL, SSP_SCK, SSP_MOSI
  );
endinterface

// File: rtl/ssp_mstr.sv
// ssp_mstr: SPI mode 0 initiator for the SSP_UART register slave.
// Each accepted host command {RA, WnR, DI} is sent as one 16-bit MSB-first
// frame; the last 12 bits clocked in from MISO are returned on RdData.
// Optional feature macro: SSP_MSTR_PIPE_EN adds a one-entry command holding
// register so a new command can be accepted while a frame is in progress.
module ssp_mstr #(
  parameter int unsigned pClkDiv = 2,
  parameter int unsigned pGap    = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  ssp_mstr_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SHIFT_H = 3'd2,
    SHIFT_L = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(pClkDiv - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(pGap - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic [11:0] rx_q, rx_d;
  logic        wnr_q, wnr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rdvld_q, rdvld_d;
  logic [11:0] rddata_q, rddata_d;
  logic        ssel_q, ssel_d;
  logic        sck_q, sck_d;

`ifdef SSP_MSTR_PIPE_EN
  logic [15:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
`endif

  logic [15:0] req_frame;
  logic        cnt_done;
  logic        gap_exit;
  logic        ack;
  logic        load_en;
  logic [15:0] load_frame;

  assign req_frame = {bus.RA, bus.WnR, bus.DI};
  assign cnt_done  = (cnt_q == 8'd0);
  assign gap_exit  = (state_q == GAP) && cnt_done;

`ifdef SSP_MSTR_PIPE_EN
  assign ack = Rst & bus.Req & ((state_q == IDLE) | ~hold_vld_q | gap_exit);
`else
  assign ack = Rst & bus.Req & (state_q == IDLE);
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_done ? cnt_q : cnt_q - 8'd1;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    wnr_d      = wnr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rdvld_d    = 1'b0;
    rddata_d   = rddata_q;
    ssel_d     = ssel_q;
    sck_d      = sck_q;
    load_en    = 1'b0;
    load_frame = 16'h0000;
`ifdef SSP_MSTR_PIPE_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (ack && (state_q != IDLE) && !gap_exit) begin
      hold_d     = req_frame;
      hold_vld_d = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (ack) begin
          load_en    = 1'b1;
          load_frame = req_frame;
        end
      end

      SETUP: begin
        if (cnt_done) begin
          state_d = SHIFT_H;
          sck_d   = 1'b1;
          cnt_d   = DIV_RELOAD;
        end
      end

      SHIFT_H: begin
        if (cnt_q == DIV_RELOAD) begin
          rx_d = {rx_q[10:0], bus.SSP_MISO};
        end
        if (cnt_done) begin
          bit_d = bit_q + 4'd1;
          sck_d = 1'b0;
          cnt_d = DIV_RELOAD;
          if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            state_d = SHIFT_L;
            tx_d    = {tx_q[14:0], 1'b0};
          end
        end
      end

      SHIFT_L: begin
        if (cnt_done) begin
          state_d = SHIFT_H;
          sck_d   = 1'b1;
          cnt_d   = DIV_RELOAD;
        end
      end

      HOLD: begin
        if (cnt_done) begin
          state_d  = GAP;
          ssel_d   = 1'b0;
          tx_d     = 16'h0000;
          done_d   = 1'b1;
          rdvld_d  = ~wnr_q;
          rddata_d = rx_q;
          cnt_d    = GAP_RELOAD;
        end
      end

      GAP: begin
        if (cnt_done) begin
`ifdef SSP_MSTR_PIPE_EN
          if (hold_vld_q) begin
            load_en    = 1'b1;
            load_frame = hold_q;
            hold_vld_d = ack;
            hold_d     = req_frame;
          end else if (ack) begin
            load_en    = 1'b1;
            load_frame = req_frame;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ssel_d  = 1'b0;
        sck_d   = 1'b0;
        tx_d    = 16'h0000;
      end
    endcase

    if (load_en) begin
      state_d = SETUP;
      tx_d    = load_frame;
      wnr_d   = load_frame[12];
      ssel_d  = 1'b1;
      sck_d   = 1'b0;
      busy_d  = 1'b1;
      bit_d   = 4'd0;
      cnt_d   = DIV_RELOAD;
    end
  end

  // State and output registers; reset aborts any frame in flight at once.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 4'd0;
      tx_q       <= 16'h0000;
      rx_q       <= 12'h000;
      wnr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdvld_q    <= 1'b0;
      rddata_q   <= 12'h000;
      ssel_q     <= 1'b0;
      sck_q      <= 1'b0;
`ifdef SSP_MSTR_PIPE_EN
      hold_q     <= 16'h0000;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      wnr_q      <= wnr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdvld_q    <= rdvld_d;
      rddata_q   <= rddata_d;
      ssel_q     <= ssel_d;
      sck_q      <= sck_d;
`ifdef SSP_MSTR_PIPE_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

  assign bus.Ack      = ack;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.RdVld    = rdvld_q;
  assign bus.RdData   = rddata_q;
  assign bus.SSP_SSEL = ssel_q;
  assign bus.SSP_SCK  = sck_q;
  assign bus.SSP_MOSI = tx_q[15];

endmodule

// File: tb/tb_ssp_mstr.sv
// tb_ssp_mstr: self-checking bench for ssp_mstr.
// dut_a runs with pClkDiv=2 and carries the table-driven frames, the busy-pulse
// case and the mid-frame reset; dut_b runs with pClkDiv=1 for frame spacing.
module tb_ssp_mstr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

`ifdef SSP_MSTR_PIPE_EN
  localparam int NCMD = 3;
`else
  localparam int NCMD = 2;
`endif

  typedef struct {
    logic [2:0]  ra;
    logic        wnr;
    logic [11:0] di;
    logic [15:0] miso;
    logic [15:0] exp_mosi;
    logic [11:0] exp_rd;
    logic        exp_vld;
  } vec_t;

  vec_t vecs [5];

  logic        obs_acked;
  logic [15:0] obs_mosi;
  int          obs_rises;
  int          obs_ssel;
  int          obs_done_at;
  int          obs_dones;
  logic [11:0] obs_rd;
  logic        obs_vld;
  logic        obs_busy1;

  // Free-running system clock.
  always #5 clk = ~clk;

  ssp_mstr_if bus_a ();
  ssp_mstr_if bus_b ();

  ssp_mstr #(.pClkDiv(2), .pGap(4)) dut_a (.Clk(clk), .Rst(rst_n), .bus(bus_a));
  ssp_mstr #(.pClkDiv(1), .pGap(4)) dut_b (.Clk(clk), .Rst(rst_n), .bus(bus_b));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitAckA(output logic ok);
    ok = 1'b0;
    for (int w = 0; w < 100 && !ok; w++) begin
      #1;
      if (bus_a.Ack) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic       sck_prev;
    int         rises;
    logic       ok;
    logic [3:0] idx;
    obs_mosi    = 16'h0000;
    obs_rises   = 0;
    obs_ssel    = 0;
    obs_done_at = -1;
    obs_dones   = 0;
    obs_rd      = 12'h000;
    obs_vld     = 1'b0;
    obs_busy1   = 1'b0;
    bus_a.SSP_MISO = v.miso[15];
    @(negedge clk);
    bus_a.RA  = v.ra;
    bus_a.WnR = v.wnr;
    bus_a.DI  = v.di;
    bus_a.Req = 1'b1;
    waitAckA(ok);
    obs_acked = ok;
    sck_prev = 1'b0;
    rises = 0;
    if (ok) begin
      for (int n = 1; n <= 200 && obs_dones == 0; n++) begin
        @(negedge clk);
        bus_a.Req = 1'b0;
        if (n == 1) obs_busy1 = bus_a.Busy;
        if (bus_a.SSP_SSEL) obs_ssel++;
        if (bus_a.SSP_SCK && !sck_prev) begin
          rises++;
          obs_mosi = {obs_mosi[14:0], bus_a.SSP_MOSI};
        end
        sck_prev = bus_a.SSP_SCK;
        if (!bus_a.SSP_SCK && rises < 16) begin
          idx = 4'(15 - rises);
          bus_a.SSP_MISO = v.miso[idx];
        end
        if (bus_a.Done) begin
          obs_dones++;
          obs_done_at = n;
          obs_rd  = bus_a.RdData;
          obs_vld = bus_a.RdVld;
        end
      end
    end
    bus_a.Req = 1'b0;
    obs_rises = rises;
  endtask

  task automatic checkFrame(input string tag, input vec_t v);
    checkOutput({tag, "_ack"},     32'(obs_acked), 32'd1);
    checkOutput({tag, "_busy"},    32'(obs_busy1), 32'd1);
    checkOutput({tag, "_mosi"},    32'(obs_mosi), 32'(v.exp_mosi));
    checkOutput({tag, "_rises"},   32'(obs_rises), 32'd16);
    checkOutput({tag, "_sselhi"},  32'(obs_ssel), 32'd66);
    checkOutput({tag, "_doneat"},  32'(obs_done_at), 32'd67);
    checkOutput({tag, "_dones"},   32'(obs_dones), 32'd1);
    checkOutput({tag, "_rddata"},  32'(obs_rd), 32'(v.exp_rd));
    checkOutput({tag, "_rdvld"},   32'(obs_vld), 32'(v.exp_vld));
  endtask

  task automatic runBackToBack();
    int   acks, dones, his, los, hi_run, lo_run;
    int   ack_t [4];
    int   done_t [4];
    int   hi_len [4];
    int   lo_len [4];
    logic prev_ssel, drop_next, seen_frame, busy_at_ack2;
    acks = 0; dones = 0; his = 0; los = 0; hi_run = 0; lo_run = 0;
    prev_ssel = 1'b0; drop_next = 1'b0; seen_frame = 1'b0; busy_at_ack2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_t[i] = -1; done_t[i] = -1; hi_len[i] = -1; lo_len[i] = -1;
    end
    bus_b.SSP_MISO = 1'b0;
    @(negedge clk);
    bus_b.RA  = 3'b100;
    bus_b.WnR = 1'b1;
    bus_b.DI  = 12'h555;
    bus_b.Req = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) @(negedge clk);
      if (drop_next) bus_b.Req = 1'b0;
      #1;
      if (bus_b.Req && bus_b.Ack) begin
        if (acks < 4) ack_t[acks] = n;
        if (acks == 1) busy_at_ack2 = bus_b.Busy;
        acks++;
        if (acks == NCMD) drop_next = 1'b1;
      end
      if (bus_b.Done) begin
        if (dones < 4) done_t[dones] = n;
        dones++;
      end
      if (bus_b.SSP_SSEL) begin
        if (!prev_ssel && seen_frame) begin
          if (los < 4) lo_len[los] = lo_run;
          los++;
        end
        hi_run++;
        seen_frame = 1'b1;
      end else if (prev_ssel) begin
        if (his < 4) hi_len[his] = hi_run;
        his++;
        hi_run = 0;
        lo_run = 1;
      end else begin
        lo_run++;
      end
      prev_ssel = bus_b.SSP_SSEL;
    end
    bus_b.Req = 1'b0;
    checkOutput("b2b_acks",    32'(acks), 32'(NCMD));
    checkOutput("b2b_dones",   32'(dones), 32'(NCMD));
    checkOutput("b2b_doneat",  32'(done_t[0] - ack_t[0]), 32'd34);
    checkOutput("b2b_hi0",     32'(hi_len[0]), 32'd33);
    checkOutput("b2b_hi1",     32'(hi_len[1]), 32'd33);
`ifdef SSP_MSTR_PIPE_EN
    checkOutput("b2b_ack2at",  32'(ack_t[1] - ack_t[0]), 32'd1);
    checkOutput("b2b_ack2bsy", 32'(busy_at_ack2), 32'd1);
    checkOutput("b2b_ack3at",  32'(ack_t[2] - ack_t[0]), 32'd37);
    checkOutput("b2b_ack3aft", 32'(ack_t[2] > done_t[0]), 32'd1);
    checkOutput("b2b_hi2",     32'(hi_len[2]), 32'd33);
    checkOutput("b2b_lo0",     32'(lo_len[0]), 32'd4);
    checkOutput("b2b_lo1",     32'(lo_len[1]), 32'd4);
`else
    checkOutput("b2b_ack2at",  32'(ack_t[1] - ack_t[0]), 32'd38);
    checkOutput("b2b_ack2bsy", 32'(busy_at_ack2), 32'd0);
    checkOutput("b2b_lo0",     32'(lo_len[0]), 32'd5);
`endif
  endtask

`ifndef SSP_MSTR_PIPE_EN
  task automatic runBusyPulse();
    logic ok, prev_ssel;
    int   acks, dones, ssel_rises;
    bus_a.SSP_MISO = 1'b0;
    @(negedge clk);
    bus_a.RA  = 3'b001;
    bus_a.WnR = 1'b0;
    bus_a.DI  = 12'h000;
    bus_a.Req = 1'b1;
    waitAckA(ok);
    checkOutput("pulse_first_ack", 32'(ok), 32'd1);
    @(negedge clk);
    bus_a.Req = 1'b0;
    repeat (10) @(negedge clk);
    bus_a.Req = 1'b1;
    #1;
    checkOutput("pulse_busy_ack", 32'(bus_a.Ack), 32'd0);
    acks = 0; dones = 0; ssel_rises = 0; prev_ssel = bus_a.SSP_SSEL;
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      bus_a.Req = 1'b0;
      if (bus_a.Ack) acks++;
      if (bus_a.Done) dones++;
      if (bus_a.SSP_SSEL && !prev_ssel) ssel_rises++;
      prev_ssel = bus_a.SSP_SSEL;
    end
    checkOutput("pulse_acks",  32'(acks), 32'd0);
    checkOutput("pulse_dones", 32'(dones), 32'd1);
    checkOutput("pulse_extra", 32'(ssel_rises), 32'd0);
  endtask
`endif

  task automatic runResetMidFrame();
    logic ok, prev;
    int   rises, dones, ssel_hi;
    vec_t rec;
    bus_a.SSP_MISO = 1'b0;
    @(negedge clk);
    bus_a.RA  = 3'b110;
    bus_a.WnR = 1'b1;
    bus_a.DI  = 12'hFFF;
    bus_a.Req = 1'b1;
    waitAckA(ok);
    checkOutput("rst_frame_ack", 32'(ok), 32'd1);
    rises = 0;
    prev = 1'b0;
    for (int n = 0; n < 200 && rises < 8; n++) begin
      @(negedge clk);
      bus_a.Req = 1'b0;
      if (bus_a.SSP_SCK && !prev) rises++;
      prev = bus_a.SSP_SCK;
    end
    checkOutput("rst_pins_before", 32'({bus_a.SSP_SSEL, bus_a.SSP_SCK, bus_a.SSP_MOSI, bus_a.Busy}), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_pins_async",
                32'({bus_a.SSP_SSEL, bus_a.SSP_SCK, bus_a.SSP_MOSI, bus_a.Busy, bus_a.Done}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    ssel_hi = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus_a.Done) dones++;
      if (bus_a.SSP_SSEL) ssel_hi++;
    end
    checkOutput("rst_no_done",   32'(dones), 32'd0);
    checkOutput("rst_no_resume", 32'(ssel_hi), 32'd0);
    rec = '{3'b011, 1'b1, 12'h001, 16'h0000, 16'h7001, 12'h000, 1'b0};
    applyStimulus(rec);
    checkFrame("rst_recover", rec);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    bus_a.Req = 1'b0; bus_a.RA = 3'b000; bus_a.WnR = 1'b0; bus_a.DI = 12'h000; bus_a.SSP_MISO = 1'b0;
    bus_b.Req = 1'b0; bus_b.RA = 3'b000; bus_b.WnR = 1'b0; bus_b.DI = 12'h000; bus_b.SSP_MISO = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{3'b010, 1'b1, 12'hA5C, 16'h0000, 16'h5A5C, 12'h000, 1'b0};
    vecs[1] = '{3'b101, 1'b0, 12'h000, 16'h03C7, 16'hA000, 12'h3C7, 1'b1};
    vecs[2] = '{3'b111, 1'b1, 12'hFFF, 16'hFFFF, 16'hFFFF, 12'hFFF, 1'b0};
    vecs[3] = '{3'b000, 1'b0, 12'h123, 16'h8001, 16'h0123, 12'h001, 1'b1};
    vecs[4] = '{3'b001, 1'b1, 12'h800, 16'h7FFE, 16'h3800, 12'hFFE, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_a", 32'({bus_a.Ack, bus_a.Busy, bus_a.Done, bus_a.RdVld, bus_a.SSP_SSEL,
                                bus_a.SSP_SCK, bus_a.SSP_MOSI, bus_a.RdData}), 32'h0);
    checkOutput("reset_b", 32'({bus_b.Ack, bus_b.Busy, bus_b.Done, bus_b.RdVld, bus_b.SSP_SSEL,
                                bus_b.SSP_SCK, bus_b.SSP_MOSI, bus_b.RdData}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkFrame($sformatf("vec%0d", i), vecs[i]);
    end

    runBackToBack();
`ifndef SSP_MSTR_PIPE_EN
    runBusyPulse();
`endif
    runResetMidFrame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
